// File: rtl/nios_cpu_ram_tester.sv
// RAM bring-up master: FILL writes seed+i over a wrapping word range, CHECK reads it back and logs mismatches.
// One access per cycle in RUN (no waitrequest); cmd_ready only in IDLE; abort stops issue and lets in-flight reads finish.
module nios_cpu_ram_tester #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_mode,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [ADDR_W:0]     cmd_count,
  input  logic [DATA_W-1:0]   cmd_seed,
  input  logic                abort,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data,
  output logic                first_err_valid
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int BE_W  = DATA_W / 8;
  localparam int RL    = READ_LATENCY;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Release of reset is re-timed to clk; assertion stays asynchronous.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                aborted_q, aborted_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0]   ferr_data_q, ferr_data_d;
  logic                ferr_vld_q, ferr_vld_d;
  logic [RL-1:0]       pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0]   pipe_exp_q  [RL];
  logic [DATA_W-1:0]   pipe_exp_d  [RL];
  logic [ADDR_W-1:0]   pipe_addr_q [RL];
  logic [ADDR_W-1:0]   pipe_addr_d [RL];

  logic                issue, last, push, miss;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_pat;

  // Abort gates the strobe in the same cycle, so the word being offered is never issued.
  assign issue    = (state_q == S_RUN) && !abort;
  assign last     = (idx_q == count_q - CNT_W'(1));
  assign cur_addr = base_q + idx_q[ADDR_W-1:0];
  assign cur_pat  = seed_q + DATA_W'(idx_q);
  assign push     = issue && mode_q;
  assign miss     = pipe_vld_q[RL-1] && (readdata != pipe_exp_q[RL-1]);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    count_d     = count_q;
    seed_d      = seed_q;
    idx_d       = idx_q;
    aborted_d   = aborted_q;
    err_count_d = err_count_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    ferr_vld_d  = ferr_vld_q;

    pipe_vld_d[0]  = push;
    pipe_exp_d[0]  = cur_pat;
    pipe_addr_d[0] = cur_addr;
    for (int i = 1; i < RL; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_exp_d[i]  = pipe_exp_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    if (miss) begin
      if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
      if (!ferr_vld_q) begin
        ferr_vld_d  = 1'b1;
        ferr_addr_d = pipe_addr_q[RL-1];
        ferr_data_d = readdata;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d      = cmd_mode;
          base_d      = cmd_base;
          count_d     = cmd_count;
          seed_d      = cmd_seed;
          idx_d       = '0;
          aborted_d   = 1'b0;
          err_count_d = '0;
          ferr_vld_d  = 1'b0;
          state_d     = (cmd_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          idx_d = idx_q + CNT_W'(1);
          if (last) state_d = mode_q ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        if (pipe_vld_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      base_q      <= '0;
      count_q     <= '0;
      seed_q      <= '0;
      idx_q       <= '0;
      aborted_q   <= 1'b0;
      err_count_q <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      ferr_vld_q  <= 1'b0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RL; i++) begin
        pipe_exp_q[i]  <= '0;
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      count_q     <= count_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      aborted_q   <= aborted_d;
      err_count_q <= err_count_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      ferr_vld_q  <= ferr_vld_d;
      pipe_vld_q  <= pipe_vld_d;
      for (int i = 0; i < RL; i++) begin
        pipe_exp_q[i]  <= pipe_exp_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  assign chipselect      = issue;
  assign write           = issue && !mode_q;
  assign address         = issue ? cur_addr : '0;
  assign writedata       = write ? cur_pat : '0;
  assign byteenable      = {BE_W{issue}};
  assign clken           = 1'b1;
  assign cmd_ready       = (state_q == S_IDLE);
  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign aborted         = aborted_q;
  assign err_count       = err_count_q;
  assign first_err_addr  = ferr_addr_q;
  assign first_err_data  = ferr_data_q;
  assign first_err_valid = ferr_vld_q;

endmodule
